// File: rtl/membrane_update_engine.sv
// Pipelined membrane update: captures one snapshot, applies reset-on-spike then beta decay
// LANES neurons per beat, and returns the full updated vector over a valid/ready handshake.
module membrane_update_engine #(
  parameter int unsigned N_NEURONS  = 16,
  parameter int unsigned POT_W      = 8,
  parameter int unsigned BETA_W     = 4,
  parameter int unsigned LANES      = 4,
  parameter int unsigned RESET_MODE = 0,
  parameter int unsigned THRESH     = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_NEURONS*POT_W-1:0]       in_potential,
  input  logic [N_NEURONS-1:0]             in_spk,
  input  logic [N_NEURONS*BETA_W-1:0]      in_beta,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_NEURONS*POT_W-1:0]       out_potential,
  output logic [$clog2(N_NEURONS+1)-1:0]   out_spk_count
);

  localparam int unsigned BEATS  = N_NEURONS / LANES;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned CNT_W  = $clog2(N_NEURONS + 1);
  localparam int unsigned ACC_W  = POT_W + BETA_W;
  localparam logic [POT_W-1:0] THRESH_V = POT_W'(THRESH);

  if (N_NEURONS % LANES != 0) begin : g_bad_lanes
    $error("N_NEURONS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                      r_state, w_state_next;
  logic [N_NEURONS*POT_W-1:0]  r_pot;
  logic [N_NEURONS-1:0]        r_spk;
  logic [N_NEURONS*BETA_W-1:0] r_beta;
  logic [BEAT_W-1:0]           r_beat;
  logic                        r_s1_valid;
  logic [BEAT_W-1:0]           r_s1_grp;
  logic [LANES*POT_W-1:0]      r_s1_pot;
  logic [LANES*BETA_W-1:0]     r_s1_beta;

  logic                        w_accept;
  logic                        w_issue;
  logic                        w_last_write;
  int unsigned                 w_base;
  logic [LANES*POT_W-1:0]      w_rst_pot;
  logic [LANES*BETA_W-1:0]     w_grp_beta;
  logic [LANES*POT_W-1:0]      w_decay;
  logic [CNT_W-1:0]            w_popcount;

  function automatic logic [POT_W-1:0] f_reset(input logic [POT_W-1:0] pot, input logic spk);
    if (!spk) return pot;
    if (RESET_MODE != 0 && pot >= THRESH_V) return pot - THRESH_V;
    return '0;
  endfunction

  // Shift-add multiply by beta, then drop BETA_W fraction bits; result never exceeds r.
  function automatic logic [POT_W-1:0] f_decay(input logic [POT_W-1:0] r,
                                               input logic [BETA_W-1:0] beta);
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < BETA_W; k++) begin
      if (beta[k]) acc = acc + (ACC_W'(r) << k);
    end
    return acc[ACC_W-1:BETA_W];
  endfunction

  assign w_accept     = in_valid && in_ready;
  assign w_issue      = r_beat < BEAT_W'(BEATS);
  assign w_last_write = r_s1_valid && (r_s1_grp == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StRun;
      end
      StRun: begin
        if (w_last_write) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pot  <= '0;
      r_spk  <= '0;
      r_beta <= '0;
    end else if (w_accept) begin
      r_pot  <= in_potential;
      r_spk  <= in_spk;
      r_beta <= in_beta;
    end
  end

  always_comb begin
    w_base     = w_issue ? 32'(r_beat) * LANES : 0;
    w_rst_pot  = '0;
    w_grp_beta = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_rst_pot[l*POT_W +: POT_W]    = f_reset(r_pot[(w_base + l)*POT_W +: POT_W], r_spk[w_base + l]);
      w_grp_beta[l*BETA_W +: BETA_W] = r_beta[(w_base + l)*BETA_W +: BETA_W];
    end
  end

  always_comb begin
    w_decay = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_decay[l*POT_W +: POT_W] = f_decay(r_s1_pot[l*POT_W +: POT_W],
                                          r_s1_beta[l*BETA_W +: BETA_W]);
    end
  end

  always_comb begin
    w_popcount = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      w_popcount = w_popcount + CNT_W'(r_spk[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat        <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_grp      <= '0;
      r_s1_pot      <= '0;
      r_s1_beta     <= '0;
      out_potential <= '0;
      out_spk_count <= '0;
    end else if (w_accept) begin
      r_beat     <= '0;
      r_s1_valid <= 1'b0;
    end else if (r_state == StRun) begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_pot  <= w_rst_pot;
        r_s1_beta <= w_grp_beta;
        r_s1_grp  <= r_beat;
        r_beat    <= r_beat + 1'b1;
      end
      if (r_s1_valid) begin
        out_potential[32'(r_s1_grp)*LANES*POT_W +: LANES*POT_W] <= w_decay;
      end
      // r_beat is zero only on the first RUN edge, one edge after accept.
      if (r_beat == '0) out_spk_count <= w_popcount;
    end
  end

endmodule

// File: tb/tb_membrane_update_engine.sv
// Randomized scoreboard bench: two engine instances (default params, and a wide RESET_MODE=1
// build) checked against an arithmetic per-neuron model.
module tb_membrane_update_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
  logic [127:0] in_pot0 = '0, out_pot0;
  logic [15:0]  in_spk0 = '0;
  logic [63:0]  in_beta0 = '0;
  logic [4:0]   out_cnt0;

  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [383:0] in_pot1 = '0, out_pot1;
  logic [31:0]  in_spk1 = '0;
  logic [191:0] in_beta1 = '0;
  logic [5:0]   out_cnt1;

  membrane_update_engine u_dut0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_potential(in_pot0), .in_spk(in_spk0), .in_beta(in_beta0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_potential(out_pot0),
    .out_spk_count(out_cnt0)
  );

  membrane_update_engine #(
    .N_NEURONS(32), .POT_W(12), .BETA_W(6), .LANES(8), .RESET_MODE(1), .THRESH(64)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_potential(in_pot1), .in_spk(in_spk1), .in_beta(in_beta1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_potential(out_pot1),
    .out_spk_count(out_cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] q_pot0[$];
  int unsigned  q_cnt0[$];
  logic [383:0] q_pot1[$];
  int unsigned  q_cnt1[$];

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned model_neuron(input int unsigned pot, input bit spk,
                                               input int unsigned beta, input int unsigned betaw,
                                               input int unsigned mode, input int unsigned thr);
    int unsigned r;
    if (!spk) r = pot;
    else if (mode != 0 && pot >= thr) r = pot - thr;
    else r = 0;
    return (r * beta) / (1 << betaw);
  endfunction

  function automatic logic [127:0] model0(input logic [127:0] pot, input logic [15:0] spk,
                                          input logic [63:0] beta);
    logic [127:0] m;
    for (int i = 0; i < 16; i++)
      m[i*8 +: 8] = 8'(model_neuron(pot[i*8 +: 8], spk[i], beta[i*4 +: 4], 4, 0, 64));
    return m;
  endfunction

  function automatic logic [383:0] model1(input logic [383:0] pot, input logic [31:0] spk,
                                          input logic [191:0] beta);
    logic [383:0] m;
    for (int i = 0; i < 32; i++)
      m[i*12 +: 12] = 12'(model_neuron(pot[i*12 +: 12], spk[i], beta[i*6 +: 6], 6, 1, 64));
    return m;
  endfunction

  function automatic int unsigned ones(input logic [31:0] v);
    int unsigned c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // Monitors: pop the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      if (q_pot0.size() == 0) check("dut0_unexpected_output", 1, 0);
      else begin
        check("dut0_potential", out_pot0, q_pot0.pop_front());
        check("dut0_spk_count", out_cnt0, q_cnt0.pop_front());
      end
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (q_pot1.size() == 0) check("dut1_unexpected_output", 1, 0);
      else begin
        check("dut1_potential", out_pot1, q_pot1.pop_front());
        check("dut1_spk_count", out_cnt1, q_cnt1.pop_front());
      end
    end
  end

  task automatic junk0();
    in_pot0 = {$urandom, $urandom, $urandom, $urandom};
    in_spk0 = 16'($urandom);
    in_beta0 = {$urandom, $urandom};
  endtask

  // Called #1 after a posedge with DUT0 idle.
  task automatic run0(input logic [127:0] pot, input logic [15:0] spk, input logic [63:0] beta,
                      input int hold, input bit poke);
    int lat = 0;
    in_pot0 = pot; in_spk0 = spk; in_beta0 = beta; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    q_pot0.push_back(model0(pot, spk, beta));
    q_cnt0.push_back(ones({16'd0, spk}));
    junk0();
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      junk0();
    end
    check("dut0_latency", lat, 5);
    for (int i = 0; i < hold; i++) begin
      if (poke) in_valid0 = 1'b1;
      check("dut0_hold_in_ready", in_ready0, 0);
      check("dut0_hold_out_valid", out_valid0, 1);
      if (poke && q_pot0.size() != 0) check("dut0_hold_potential", out_pot0, q_pot0[0]);
      @(posedge clk); #1;
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    in_valid0 = 1'b0;
    check("dut0_after_handshake_out_valid", out_valid0, 0);
    check("dut0_after_handshake_in_ready", in_ready0, 1);
  endtask

  task automatic run1(input logic [383:0] pot, input logic [31:0] spk, input logic [191:0] beta,
                      input int hold);
    int lat = 0;
    in_pot1 = pot; in_spk1 = spk; in_beta1 = beta; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    q_pot1.push_back(model1(pot, spk, beta));
    q_cnt1.push_back(ones(spk));
    in_spk1 = $urandom;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("dut1_latency", lat, 5);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("dut1_after_handshake_out_valid", out_valid1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p0;
    logic [15:0]  s0;
    logic [63:0]  b0;
    logic [383:0] p1;
    logic [31:0]  s1;
    logic [191:0] b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready0, 1);
    check("reset_out_valid", out_valid0, 0);
    check("reset_out_potential", out_pot0, 0);
    check("reset_spk_count", out_cnt0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin p0[i*8 +: 8] = 8'd100; b0[i*4 +: 4] = 4'd8; end
    run0(p0, 16'd0, b0, 2, 1'b0);

    for (int i = 0; i < 16; i++) begin p0[i*8 +: 8] = 8'd200; b0[i*4 +: 4] = 4'd15; end
    run0(p0, 16'h0001, b0, 0, 1'b0);

    junk0();
    run0(in_pot0, in_spk0, in_beta0, 10, 1'b1);

    // Abort mid-run: reset sampled at T0+2.
    junk0();
    in_spk0 = 16'hffff;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", in_ready0, 1);
    check("abort_out_valid", out_valid0, 0);
    check("abort_out_potential", out_pot0, 0);
    check("abort_spk_count", out_cnt0, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_result", out_valid0, 0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 16; i++) begin
        p0[i*8 +: 8] = 8'($urandom);
        b0[i*4 +: 4] = 4'($urandom);
        s0[i] = ($urandom_range(0, 2) == 0);
      end
      run0(p0, s0, b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 32; i++) begin
      p1[i*12 +: 12] = 12'($urandom); b1[i*6 +: 6] = 6'($urandom); s1[i] = 1'b0;
    end
    p1[11:0] = 12'd100; s1[0] = 1'b1; b1[5:0] = 6'd32;
    p1[23:12] = 12'd30; s1[1] = 1'b1;
    run1(p1, s1, b1, 1);

    for (int i = 0; i < 32; i++) begin p1[i*12 +: 12] = 12'd4095; b1[i*6 +: 6] = 6'd63; end
    run1(p1, 32'd0, b1, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) begin
        p1[i*12 +: 12] = 12'($urandom);
        b1[i*6 +: 6] = 6'($urandom);
        s1[i] = ($urandom_range(0, 1) == 0);
      end
      run1(p1, s1, b1, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("dut0_scoreboard_drained", q_pot0.size(), 0);
    check("dut1_scoreboard_drained", q_pot1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
